// File: rtl/cnn_out_sched.sv
// cnn_out_sched: sweeps the X grid through the CNN output function into Y.
// Optional: define CNN_SAT_GUARD_EN to map the most negative X to -1.
module eq2 #(
  parameter int W = 17
) (
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] xp, xm, ap, am, d;

  // Y = (|X+1| - |X-1|) / 2, all terms wrap at W bits
  always_comb begin
    xp = x + W'(1);
    xm = x - W'(1);
    ap = xp[W-1] ? -xp : xp;
    am = xm[W-1] ? -xm : xm;
    d  = ap - am;
    y  = d >>> 1;
  end

endmodule

module cnn_out_sched #(
  parameter int WIDTH  = 9,
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 6,
  parameter int ITER_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ITER_W-1:0]         num_iter,
  output logic                      busy,
  output logic                      done,
  output logic [ITER_W-1:0]         iter_cnt,
  output logic                      x_rd_en,
  output logic [ADDR_W-1:0]         x_rd_addr,
  input  logic signed [2*WIDTH-2:0] x_rd_data,
  output logic                      y_wr_en,
  output logic [ADDR_W-1:0]         y_wr_addr,
  output logic signed [2*WIDTH-2:0] y_wr_data,
  input  logic                      y_wr_ready
);

  localparam int XW    = 2 * WIDTH - 1;
  localparam int CELLS = ROWS * COLS;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

  typedef enum logic [2:0] {
    IDLE, RD, LAT, WR, DONE
  } state_t;

  state_t state, nxt;

  logic [ADDR_W-1:0]   addr, addr_n;
  logic [ITER_W-1:0]   iter, iter_n;
  logic [ITER_W-1:0]   num, num_n;
  logic signed [XW-1:0] ydat, ydat_n;
  logic signed [XW-1:0] fy, yv;

  eq2 #(.W(XW)) u_eq2 (
    .x (x_rd_data),
    .y (fy)
  );

`ifdef CNN_SAT_GUARD_EN
  localparam logic signed [XW-1:0] XMIN =
    {1'b1, {(XW-1){1'b0}}};
  assign yv = (x_rd_data == XMIN) ? '1 : fy;
`else
  assign yv = fy;
`endif

  always_comb begin
    nxt    = state;
    addr_n = addr;
    iter_n = iter;
    num_n  = num;
    ydat_n = ydat;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_iter != '0) begin
            num_n  = num_iter;
            addr_n = '0;
            iter_n = '0;
            nxt    = RD;
          end else begin
            nxt = DONE;
          end
        end
      end
      RD: nxt = LAT;
      LAT: begin
        ydat_n = yv;
        nxt    = WR;
      end
      WR: begin
        if (y_wr_ready) begin
          if (addr != LAST) begin
            addr_n = addr + ADDR_W'(1);
            nxt    = RD;
          end else if (iter != num - ITER_W'(1)) begin
            addr_n = '0;
            iter_n = iter + ITER_W'(1);
            nxt    = RD;
          end else begin
            nxt = DONE;
          end
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      iter  <= '0;
      num   <= '0;
      ydat  <= '0;
    end else begin
      state <= nxt;
      addr  <= addr_n;
      iter  <= iter_n;
      num   <= num_n;
      ydat  <= ydat_n;
    end
  end

  assign busy      = (state == RD) || (state == LAT) ||
                     (state == WR);
  assign done      = (state == DONE);
  assign x_rd_en   = (state == RD);
  assign x_rd_addr = addr;
  assign y_wr_en   = (state == WR);
  assign y_wr_addr = addr;
  assign y_wr_data = ydat;
  assign iter_cnt  = iter;

endmodule

// File: tb/tb_cnn_out_sched.sv
// tb_cnn_out_sched: scoreboard bench for cnn_out_sched on a 2x2 grid.
// Expected Y values and write cycles are queued when a sweep is started.
module tb_cnn_out_sched;

  localparam int WIDTH  = 9;
  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int ADDR_W = 6;
  localparam int ITER_W = 8;
  localparam int XW     = 2 * WIDTH - 1;
  localparam int N      = ROWS * COLS;
  localparam int XMIN   = -(2 ** (XW - 1));

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [ITER_W-1:0]    num_iter = '0;
  logic                 busy, done;
  logic [ITER_W-1:0]    iter_cnt;
  logic                 x_rd_en;
  logic [ADDR_W-1:0]    x_rd_addr;
  logic signed [XW-1:0] x_rd_data = '0;
  logic                 y_wr_en;
  logic [ADDR_W-1:0]    y_wr_addr;
  logic signed [XW-1:0] y_wr_data;
  logic                 y_wr_ready = 1'b1;

  cnn_out_sched #(
    .WIDTH  (WIDTH),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ADDR_W (ADDR_W),
    .ITER_W (ITER_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_iter   (num_iter),
    .busy       (busy),
    .done       (done),
    .iter_cnt   (iter_cnt),
    .x_rd_en    (x_rd_en),
    .x_rd_addr  (x_rd_addr),
    .x_rd_data  (x_rd_data),
    .y_wr_en    (y_wr_en),
    .y_wr_addr  (y_wr_addr),
    .y_wr_data  (y_wr_data),
    .y_wr_ready (y_wr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int it;
    int at;
  } exp_t;

  int   xmem [N];
  exp_t sbq [$];
  int   doneq [$];
  int   nvec = 0, nerr = 0;
  int   cyc = 0, c0 = 0;
  int   nrd, nbusy;
  bit   held = 0;
  int   h_addr, h_data, rel;
  exp_t e;

  task automatic check(input string tag, input int got,
                       input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int fref(input int x);
    if (x == XMIN) begin
`ifdef CNN_SAT_GUARD_EN
      return -1;
`else
      return 0;
`endif
    end
    return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (x_rd_en)
      x_rd_data <= (int'(x_rd_addr) < N) ?
                   XW'(xmem[x_rd_addr]) : '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      rel = cyc - c0;
      check("rd_wr_excl", int'(x_rd_en & y_wr_en), 0);
      if (x_rd_en) nrd++;
      if (busy) nbusy++;
      if (done) doneq.push_back(rel);
      if (y_wr_en) begin
        if (held) begin
          check("stall_addr", int'(y_wr_addr), h_addr);
          check("stall_data", int'(y_wr_data), h_data);
        end
        if (y_wr_ready) begin
          held = 0;
          if (sbq.size() == 0) begin
            check("sb_underflow", sbq.size(), 1);
          end else begin
            e = sbq.pop_front();
            check("wr_addr", int'(y_wr_addr), e.addr);
            check("wr_data", int'(y_wr_data), e.data);
            check("wr_iter", int'(iter_cnt), e.it);
            check("wr_cycle", rel, e.at);
          end
        end else begin
          held   = 1;
          h_addr = int'(y_wr_addr);
          h_data = int'(y_wr_data);
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic chk_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rden"}, int'(x_rd_en), 0);
    check({tag, "_wren"}, int'(y_wr_en), 0);
    check({tag, "_rdaddr"}, int'(x_rd_addr), 0);
    check({tag, "_wraddr"}, int'(y_wr_addr), 0);
    check({tag, "_wrdata"}, int'(y_wr_data), 0);
    check({tag, "_iter"}, int'(iter_cnt), 0);
  endtask

  task automatic do_reset(input int n);
    rst   = 1'b1;
    start = 1'b1;
    num_iter = 8'd3;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk_zero("rst");
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_exp(input int num, input bit stall);
    int k;
    sbq.delete();
    doneq.delete();
    nrd   = 0;
    nbusy = 0;
    for (int it = 0; it < num; it++)
      for (int a = 0; a < N; a++) begin
        k = it * N + a;
        sbq.push_back('{a, fref(xmem[a]), it,
                        3 + 3 * k + ((stall && k >= 1) ? 5 : 0)});
      end
  endtask

  task automatic run(input int num, input bit stall,
                     input bit poke);
    int dcyc;
    dcyc = 1 + 3 * N * num + (stall ? 5 : 0);
    load_exp(num, stall);
    start    = 1'b1;
    num_iter = ITER_W'(num);
    c0       = cyc;
    for (int k = 1; k <= dcyc + 5; k++) begin
      @(posedge clk); #1;
      start      = poke && (k == 5 || k == dcyc);
      num_iter   = start ? 8'd7 : ITER_W'(num);
      y_wr_ready = !(stall && k >= 6 && k <= 10);
    end
    start      = 1'b0;
    y_wr_ready = 1'b1;
    check("done_count", doneq.size(), 1);
    if (doneq.size() > 0) check("done_cycle", doneq[0], dcyc);
    check("sb_left", sbq.size(), 0);
    check("reads", nrd, num * N);
    check("busy_cycles", nbusy, 3 * N * num + (stall ? 5 : 0));
  endtask

  task automatic abort_run();
    load_exp(1, 0);
    start    = 1'b1;
    num_iter = 8'd1;
    c0       = cyc;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = (k == 7);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("abort");
    check("abort_sb", sbq.size(), 2);
    sbq.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_zero("abort_idle");
    end
  endtask

  initial begin
    xmem = '{5, -7, 0, 1};
    do_reset(3);
    run(1, 0, 0);
    run(3, 0, 0);
    run(1, 1, 0);
    run(0, 0, 0);
    xmem = '{XMIN, 65535, -1, 2};
    run(1, 0, 0);
    xmem = '{-3, 4, 0, -1};
    run(1, 0, 1);
    abort_run();
    run(1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
